sram_mem_controller: RTL

- Multi-cycle controller between the MEM stage and the off-chip 16-bit SRAM (256K x 16).
- Turns a single-cycle 32-bit load/store request into two sequenced half-word SRAM accesses.
- Drives `ready` low while busy; the pipeline uses `~ready` as a global freeze of PC and all stage registers.
- Returns the assembled 32-bit load word in `readData`.

---
 rtl/sram_mem_controller.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - two-phase 32-bit load/store controller for a 256K x 16 SRAM
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   wr_en, rd_en        store / load request from the MEM stage (store wins if both)
//   address, writeData  CPU byte address and store data
//   readData            assembled 32-bit load word, registered
//   ready               0 freezes the pipeline while an access is in flight
//   SRAM_*              half-word SRAM interface; UB/LB/CE/OE are tied active
module sram_mem_controller #(
    parameter int BASE_ADDR    = 1024,
    parameter int PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    localparam int CW = $clog2(PHASE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [16:0]   word_q;
    logic [15:0]   data_hi_q;
    logic [15:0]   dq_out;
    logic          dq_oe;
    logic [16:0]   word_idx;
    logic          phase_end;

    // Word index of the rebased address; the low two byte-offset bits are dropped.
    assign word_idx  = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign phase_end = (cnt == LAST);

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    // In IDLE a new request must freeze the pipeline in the same cycle it appears,
    // so ready is combinational there; elsewhere it is a pure state decode.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~(wr_en | rd_en);
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // SRAM outputs are registered alongside the state so they change exactly on
    // state boundaries; each transition sets what the next state must drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            readData  <= '0;
            word_q    <= '0;
            data_hi_q <= '0;
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            SRAM_WE_N <= 1'b1;
            SRAM_ADDR <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        word_q    <= word_idx;
                        data_hi_q <= writeData[31:16];
                        cnt       <= '0;
                        SRAM_ADDR <= {word_idx, 1'b0};
                        if (wr_en) begin
                            state     <= WR_LO;
                            SRAM_WE_N <= 1'b0;
                            dq_oe     <= 1'b1;
                            dq_out    <= writeData[15:0];
                        end else begin
                            state <= RD_LO;
                        end
                    end
                end
                RD_LO: begin
                    if (phase_end) begin
                        readData[15:0] <= SRAM_DQ;
                        cnt            <= '0;
                        state          <= RD_HI;
                        SRAM_ADDR      <= {word_q, 1'b1};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_HI: begin
                    if (phase_end) begin
                        readData[31:16] <= SRAM_DQ;
                        cnt             <= '0;
                        state           <= DONE;
                        SRAM_ADDR       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_LO: begin
                    if (phase_end) begin
                        cnt       <= '0;
                        state     <= WR_HI;
                        dq_out    <= data_hi_q;
                        SRAM_ADDR <= {word_q, 1'b1};
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_HI: begin
                    if (phase_end) begin
                        cnt       <= '0;
                        state     <= DONE;
                        SRAM_WE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        SRAM_ADDR <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    SRAM_WE_N <= 1'b1;
                    dq_oe     <= 1'b0;
                    SRAM_ADDR <= '0;
                end
            endcase
        end
    end

endmodule
